hub75_scan_driver: RTL and testbench
====================================

// Module: hub75_scan_driver
// PURPOSE
//  Drives one 64x64 1/32-scan HUB-75 panel, the consumer end of the pixel-source interface.
//  Walks the panel in scan order, issuing (x,y,t) requests to the pixel source (test pattern
//  generator or framebuffer) and taking back r/g/b after a fixed latency.
//  Shifts the upper- and lower-half pixels into the panel, latches, and displays each row.
// PARAMETERS
//  WIDTH        64   columns per row (= hub_clk pulses per row)
//  SCAN_ROWS    32   rows per half; lower-half y = row + SCAN_ROWS
//  SRC_LATENCY  2    cycles from pix_x/pix_y presented to pix_r/g/b valid; legal 0..2
//  ON_CYCLES    256  cycles hub_oe_n is held low per row (brightness)
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-low reset
//  enable       in   1   run scan; sampled only in IDLE and at row end
//  pix_x        out  6   requested column
//  pix_y        out  6   requested row (0..63)
//  pix_t        out  10  frame counter, passed to source as time
//  pix_r/g/b    in   1   source pixel, valid SRC_LATENCY cycles after request
//  hub_r1/g1/b1 out  1   upper-half data
//  hub_r2/g2/b2 out  1   lower-half data
//  hub_clk      out  1   panel shift clock (panel samples on rising edge)
//  hub_lat      out  1   panel latch strobe
//  hub_oe_n     out  1   panel output enable, active-low
//  hub_addr     out  5   panel row address
//  frame_start  out  1   1-cycle pulse when row 0 of a new frame begins shifting
// BEHAVIOUR
//  Reset (reset==0 at clock edge; wins over everything, including mid-row): state IDLE,
//   row=0, col=0, pix_x=pix_y=pix_t=0, hub data=0, hub_clk=0, hub_lat=0, hub_oe_n=1,
//   hub_addr=0, frame_start=0. All outputs are registered.
//  States: IDLE -> SHIFT -> TAIL -> BLANK -> LATCH -> DISPLAY -> (SHIFT | IDLE).
//  IDLE: hub_oe_n=1. enable=1 -> SHIFT for the current row.
//  SHIFT: WIDTH slots of 4 cycles, phase p=0..3, column c.
//   p0: pix_x=c, pix_y=row. p1: pix_x=c, pix_y=row+SCAN_ROWS. p2, p3: pix_x/pix_y hold.
//   Upper rgb is captured at the end of p(SRC_LATENCY).
//   Lower rgb is captured at the end of p(SRC_LATENCY+1).
//   At the end of p3, hub_r1..b2 load column c (upper, lower).
//   hub_clk=1 during p2 and p3 of the slot after each load: data is stable 2 cycles before
//    the rising edge and changes only at the falling edge.
//  TAIL: one 4-cycle slot with no requests; hub_clk=1 in its cycles 2-3 (clocks column WIDTH-1).
//   Exactly WIDTH rising edges of hub_clk occur per row.
//  BLANK: 2 cycles, hub_oe_n=1; hub_addr <= row in the first cycle.
//  LATCH: 1 cycle, hub_lat=1 (hub_oe_n=1, hub_clk=0).
//  DISPLAY: ON_CYCLES cycles with hub_oe_n=0.
//   Then row <= row+1; wrap SCAN_ROWS-1 -> 0 increments pix_t (mod 1024, 1023 -> 0).
//   Then: enable=1 -> SHIFT, else IDLE.
//  frame_start: high for the first SHIFT cycle of row 0, including the start from IDLE.
//  Row length = 4*WIDTH + 4 + 2 + 1 + ON_CYCLES = 519 cycles at defaults.
//  Deasserting enable mid-row has no effect until DISPLAY completes: rows are never truncated.
//  hub_oe_n=0 is only ever driven in DISPLAY; hub_lat is never high while hub_oe_n=0.
// TESTING
//  1 reset=0 for 3 cycles mid-SHIFT -> next cycle all outputs at reset values, IDLE, oe_n=1.
//  2 Source model, latency 2: r=(y<32), g=x[0], b=y[0].
//    Row 0 shifted -> per clock edge r1=1, r2=0, g1=g2=c[0], b1=b2=0.
//    Row 5 -> b1=b2=1, hub_addr=5 at latch.
//  3 enable held 1 -> SHIFT start to next SHIFT start = 519 cycles; 64 hub_clk edges per row.
//    hub_lat high exactly 1 cycle with hub_oe_n=1; hub_oe_n low exactly 256 cycles.
//  4 After 32 rows -> pix_t 0->1 and frame_start pulses 1 cycle.
//    Force pix_t=1023 via 1023 frames (or a short-frame build) -> wraps to 0.
//  5 enable=0 at row 3 slot 10 -> row 3 completes through DISPLAY, then IDLE; no further hub_clk.
//    enable=1 -> SHIFT of row 4, no frame_start.
//  6 Build with SRC_LATENCY=0 and a combinational source -> panel data identical to test 2.

Source files
------------

// File: rtl/hub75_scan_driver_if.sv
// Pixel-source bus between the HUB-75 scan driver and whatever produces pixels
// (test pattern generator, framebuffer).
//   pix_x/pix_y/pix_t : request from the driver (column, row 0..63, frame time)
//   pix_r/pix_g/pix_b : pixel from the source, valid a fixed latency after the request
// master = scan driver, slave = pixel source.
interface hub75_scan_driver_if;
  logic [5:0] pix_x;
  logic [5:0] pix_y;
  logic [9:0] pix_t;
  logic       pix_r;
  logic       pix_g;
  logic       pix_b;

  modport master (output pix_x, pix_y, pix_t, input  pix_r, pix_g, pix_b);
  modport slave  (input  pix_x, pix_y, pix_t, output pix_r, pix_g, pix_b);
endinterface

// File: rtl/hub75_scan_driver.sv
// Scan driver for one 64x64 1/32-scan HUB-75 panel.
// Walks the panel row by row: for every column it requests the upper-half and
// lower-half pixel from the source, shifts both into the panel, then blanks,
// latches and displays the row for ON_CYCLES cycles.
// Ports:
//   clock, reset      system clock, synchronous active-low reset
//   enable            run scan; sampled only in IDLE and at the end of DISPLAY
//   pix (master)      pixel-source request/response bus
//   hub_r1/g1/b1      upper-half data     hub_r2/g2/b2  lower-half data
//   hub_clk, hub_lat  panel shift clock / latch strobe
//   hub_oe_n          panel output enable, active-low
//   hub_addr          panel row address
//   frame_start       1-cycle pulse on the first shift cycle of row 0
// All outputs are registered.
module hub75_scan_driver #(
  parameter int WIDTH       = 64,
  parameter int SCAN_ROWS   = 32,
  parameter int SRC_LATENCY = 2,
  parameter int ON_CYCLES   = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  hub75_scan_driver_if.master  pix,
  output logic                 hub_r1,
  output logic                 hub_g1,
  output logic                 hub_b1,
  output logic                 hub_r2,
  output logic                 hub_g2,
  output logic                 hub_b2,
  output logic                 hub_clk,
  output logic                 hub_lat,
  output logic                 hub_oe_n,
  output logic [4:0]           hub_addr,
  output logic                 frame_start
);

  typedef enum logic [2:0] {IDLE, SHIFT, TAIL, BLANK, LATCH, DISPLAY} state_t;

  // cnt serves both the 2-cycle BLANK and the ON_CYCLES-long DISPLAY
  localparam int            CW        = $clog2(ON_CYCLES + 2);
  localparam logic [1:0]    P_UP      = 2'(SRC_LATENCY);
  localparam logic [1:0]    P_LO      = 2'(SRC_LATENCY + 1);
  localparam logic [5:0]    COL_LAST  = 6'(WIDTH - 1);
  localparam logic [4:0]    ROW_LAST  = 5'(SCAN_ROWS - 1);
  localparam logic [5:0]    LOWER_OFS = 6'(SCAN_ROWS);
  localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state, state_nx;
  logic [1:0]    phase, phase_nx;
  logic [5:0]    col, col_nx;
  logic [4:0]    row, row_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [9:0]    t_nx;
  logic [2:0]    pix_rgb, up_buf, lo_buf, up_sel, lo_sel;

  assign pix_rgb = {pix.pix_r, pix.pix_g, pix.pix_b};
  // When a pixel becomes valid in p3 itself it bypasses the buffer into the load
  assign up_sel  = (phase == P_UP) ? pix_rgb : up_buf;
  assign lo_sel  = (phase == P_LO) ? pix_rgb : lo_buf;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      phase <= '0;
      col   <= '0;
      row   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
      col   <= col_nx;
      row   <= row_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    col_nx   = col;
    row_nx   = row;
    cnt_nx   = cnt;
    t_nx     = pix.pix_t;
    case (state)
      IDLE: if (enable) begin
        state_nx = SHIFT;
        phase_nx = '0;
        col_nx   = '0;
      end
      SHIFT: begin
        phase_nx = phase + 2'd1;
        if (phase == 2'd3) begin
          if (col == COL_LAST) begin
            state_nx = TAIL;
            col_nx   = '0;
          end else begin
            col_nx = col + 6'd1;
          end
        end
      end
      TAIL: begin
        phase_nx = phase + 2'd1;
        if (phase == 2'd3) begin
          state_nx = BLANK;
          cnt_nx   = '0;
        end
      end
      BLANK: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt == CNT_ONE) state_nx = LATCH;
      end
      LATCH: begin
        state_nx = DISPLAY;
        cnt_nx   = '0;
      end
      DISPLAY: begin
        cnt_nx = cnt + CNT_ONE;
        if (cnt == ON_LAST) begin
          cnt_nx   = '0;
          phase_nx = '0;
          col_nx   = '0;
          if (row == ROW_LAST) begin
            row_nx = '0;
            t_nx   = pix.pix_t + 10'd1;
          end else begin
            row_nx = row + 5'd1;
          end
          state_nx = enable ? SHIFT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with
  // the cycle they describe.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pix.pix_x   <= '0;
      pix.pix_y   <= '0;
      pix.pix_t   <= '0;
      up_buf      <= '0;
      lo_buf      <= '0;
      {hub_r1, hub_g1, hub_b1} <= '0;
      {hub_r2, hub_g2, hub_b2} <= '0;
      hub_clk     <= 1'b0;
      hub_lat     <= 1'b0;
      hub_oe_n    <= 1'b1;
      hub_addr    <= '0;
      frame_start <= 1'b0;
    end else begin
      pix.pix_t   <= t_nx;
      frame_start <= (state_nx == SHIFT) && (state != SHIFT) && (row_nx == '0);
      if (state_nx == SHIFT && phase_nx == 2'd0) begin
        pix.pix_x <= col_nx;
        pix.pix_y <= {1'b0, row_nx};
      end else if (state_nx == SHIFT && phase_nx == 2'd1) begin
        pix.pix_y <= {1'b0, row_nx} + LOWER_OFS;
      end
      // Rising edge in p2 of the slot after each load; slot 0 has nothing to clock
      // and TAIL clocks out the last column.
      hub_clk  <= ((state_nx == SHIFT) && (col_nx != '0) && phase_nx[1]) ||
                  ((state_nx == TAIL) && phase_nx[1]);
      hub_lat  <= (state_nx == LATCH);
      hub_oe_n <= (state_nx != DISPLAY);
      if (state == TAIL && state_nx == BLANK) hub_addr <= row;
      if (state == SHIFT) begin
        if (phase == P_UP) up_buf <= pix_rgb;
        if (phase == P_LO) lo_buf <= pix_rgb;
        if (phase == 2'd3) begin
          {hub_r1, hub_g1, hub_b1} <= up_sel;
          {hub_r2, hub_g2, hub_b2} <= lo_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Bench for hub75_scan_driver: a latency-2 build fed by a pipelined source, a
// latency-0 build fed by a combinational source (both must show the same panel
// data), and a tiny-frame build used to walk pix_t through its wrap.
module tb_hub75_scan_driver;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, enable, rst_s, en_s, rand_en;
  logic [2:0] pat [64][64];
  int total = 0;
  int bad   = 0;

  hub75_scan_driver_if ifa();
  hub75_scan_driver_if ifb();
  hub75_scan_driver_if ifs();

  logic a_r1, a_g1, a_b1, a_r2, a_g2, a_b2, a_clk, a_lat, a_oe_n, a_fs;
  logic b_r1, b_g1, b_b1, b_r2, b_g2, b_b2, b_clk, b_lat, b_oe_n, b_fs;
  logic s_r1, s_g1, s_b1, s_r2, s_g2, s_b2, s_clk, s_lat, s_oe_n, s_fs;
  logic [4:0] a_addr, b_addr, s_addr;

  // Source pattern: r=(y<32), g=x[0], b=y[0], optionally scrambled by a random table
  function automatic logic [2:0] src(input int x, input int y, input logic re);
    logic [2:0] v;
    v = {(y < 32), x[0], y[0]};
    if (re) v = v ^ pat[y][x];
    return v;
  endfunction

  // Expected {upper, lower} pixel for column k of panel row r
  function automatic logic [5:0] exp_px(input int r, input int k);
    return {src(k, r, rand_en), src(k, r + 32, rand_en)};
  endfunction

  logic [2:0] a_s1, a_s2;
  always @(posedge clock) begin
    a_s1 <= src(int'(ifa.pix_x), int'(ifa.pix_y), rand_en);
    a_s2 <= a_s1;
  end
  assign {ifa.pix_r, ifa.pix_g, ifa.pix_b} = a_s2;
  assign {ifb.pix_r, ifb.pix_g, ifb.pix_b} = src(int'(ifb.pix_x), int'(ifb.pix_y), rand_en);
  assign {ifs.pix_r, ifs.pix_g, ifs.pix_b} = 3'b000;

  hub75_scan_driver #(.SRC_LATENCY(2)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .pix(ifa),
    .hub_r1(a_r1), .hub_g1(a_g1), .hub_b1(a_b1), .hub_r2(a_r2), .hub_g2(a_g2), .hub_b2(a_b2),
    .hub_clk(a_clk), .hub_lat(a_lat), .hub_oe_n(a_oe_n), .hub_addr(a_addr), .frame_start(a_fs));

  hub75_scan_driver #(.SRC_LATENCY(0)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .pix(ifb),
    .hub_r1(b_r1), .hub_g1(b_g1), .hub_b1(b_b1), .hub_r2(b_r2), .hub_g2(b_g2), .hub_b2(b_b2),
    .hub_clk(b_clk), .hub_lat(b_lat), .hub_oe_n(b_oe_n), .hub_addr(b_addr), .frame_start(b_fs));

  hub75_scan_driver #(.WIDTH(2), .SCAN_ROWS(2), .SRC_LATENCY(2), .ON_CYCLES(2)) dut_s (
    .clock(clock), .reset(rst_s), .enable(en_s), .pix(ifs),
    .hub_r1(s_r1), .hub_g1(s_g1), .hub_b1(s_b1), .hub_r2(s_r2), .hub_g2(s_g2), .hub_b2(s_b2),
    .hub_clk(s_clk), .hub_lat(s_lat), .hub_oe_n(s_oe_n), .hub_addr(s_addr), .frame_start(s_fs));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_pix_a", {ifa.pix_x, ifa.pix_y, ifa.pix_t}, 64'd0);
    chk("rst_pix_b", {ifb.pix_x, ifb.pix_y, ifb.pix_t}, 64'd0);
    chk("rst_hub_a", {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2, a_clk, a_lat, a_oe_n, a_addr, a_fs},
        {6'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0});
    chk("rst_hub_b", {b_r1, b_g1, b_b1, b_r2, b_g2, b_b2, b_clk, b_lat, b_oe_n, b_addr, b_fs},
        {6'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0});
  endtask

  // Idle for n cycles: panel dark, nothing clocked or latched
  task automatic idle_check(input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      if (!a_oe_n || a_clk || a_lat || a_fs || !b_oe_n || b_clk || b_lat) act++;
      @(negedge clock);
    end
    chk("idle_quiet", act, 0);
  endtask

  // Called at the negedge inside the first SHIFT cycle of a row; returns at the
  // negedge of the following cycle after the row's 519 cycles.
  task automatic run_row(input int r, input logic exp_fs, input int exp_t, input int drop_at);
    int edges = 0, lat_n = 0, oe_low = 0, viol = 0, fs_extra = 0, addr = -1;
    logic prev = 1'b0;
    for (int i = 0; i < 519; i++) begin
      if (i == drop_at) enable = 1'b0;
      if (i == 0) begin
        chk("frame_start", a_fs, exp_fs);
        chk("pix_x0", ifa.pix_x, 0);
        chk("pix_y_up", ifa.pix_y, r);
        chk("pix_t", ifa.pix_t, exp_t);
      end else if (a_fs) fs_extra++;
      if (i == 1) chk("pix_y_lo", ifa.pix_y, r + 32);
      if (a_clk && !prev) begin
        chk("edge_time", i, 4 * (edges + 1) + 2);
        chk("data_a", {a_r1, a_g1, a_b1, a_r2, a_g2, a_b2}, exp_px(r, edges));
        chk("data_b", {b_r1, b_g1, b_b1, b_r2, b_g2, b_b2}, exp_px(r, edges));
        edges++;
      end
      prev = a_clk;
      if (a_clk !== b_clk || a_lat !== b_lat || a_oe_n !== b_oe_n) viol++;
      if (a_lat) begin
        lat_n++;
        addr = int'(a_addr);
        chk("lat_time", i, 262);
      end
      if (!a_oe_n) oe_low++;
      if ((a_lat && !a_oe_n) || (!a_oe_n && i < 263) || (a_lat && a_clk)) viol++;
      @(negedge clock);
    end
    chk("edges", edges, 64);
    chk("lat_cycles", lat_n, 1);
    chk("oe_low", oe_low, 256);
    chk("ctrl_viol", viol, 0);
    chk("fs_extra", fs_extra, 0);
    chk("hub_addr", addr, r);
  endtask

  initial begin
    int k;
    reset = 1'b0; enable = 1'b0; rst_s = 1'b0; en_s = 1'b0; rand_en = 1'b0;
    for (int y = 0; y < 64; y++)
      for (int x = 0; x < 64; x++) pat[y][x] = 3'($urandom_range(0, 7));
    repeat (3) @(negedge clock);
    chk_reset_vals();

    // Reset mid-SHIFT
    reset = 1'b1; enable = 1'b1;
    @(negedge clock);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals();
    repeat (2) @(negedge clock);
    chk_reset_vals();
    reset = 1'b1; enable = 1'b0;
    @(negedge clock);
    idle_check($urandom_range(2, 10));

    // Frame 0: spec pattern rows 0..5, random pattern for the rest
    enable = 1'b1;
    @(negedge clock);
    run_row(0, 1'b1, 0, -1);
    for (int r = 1; r < 6; r++) run_row(r, 1'b0, 0, -1);
    rand_en = 1'b1;
    for (int r = 6; r < 32; r++) run_row(r, 1'b0, 0, -1);

    // Frame 1: pix_t advanced; enable dropped in row 3 slot 10
    run_row(0, 1'b1, 1, -1);
    run_row(1, 1'b0, 1, -1);
    run_row(2, 1'b0, 1, -1);
    run_row(3, 1'b0, 1, 40);
    idle_check($urandom_range(5, 20));
    enable = 1'b1;
    @(negedge clock);
    run_row(4, 1'b0, 1, -1);
    enable = 1'b0;

    // Tiny-frame build: pix_t must count frames and wrap 1023 -> 0
    rst_s = 1'b1; en_s = 1'b1;
    k = 0;
    for (int c = 0; c < 40000 && k <= 1024; c++) begin
      @(negedge clock);
      if (s_fs) begin
        chk("short_t", ifs.pix_t, k % 1024);
        k++;
      end
    end
    chk("short_frames", k, 1025);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
